calc_chain_engine: RTL and testbench
====================================

// Module: calc_chain_engine
// PURPOSE
//  Keypad-driven integer calculator core: accepts digit, sign and operator keys, builds signed operands,
//  and evaluates arbitrarily long left-to-right chains (a op b op c ... =). Sits between switch debounce
//  and the seg/LCD display drivers. Generalises the fixed-width add/sub core to parametrised width and
//  digit count, and adds iterative mul/div with error reporting.
// PARAMETERS
//  W          32  accumulator/operand width, signed two's complement
//  MAX_DIGITS 9   max decimal digits per operand; 10**MAX_DIGITS-1 must fit in W-1 bits
//  CNT_W      4   width of digit_cnt, >= clog2(MAX_DIGITS+1)
// PORTS
//  clk        in   1      system clock, single domain
//  rst        in   1      asynchronous, active-low reset
//  key_digit  in   10     digit keys 0..9, level inputs
//  key_neg    in   1      toggle sign of the operand being entered
//  key_add    in   1      operator +
//  key_sub    in   1      operator -
//  key_mul    in   1      operator *
//  key_div    in   1      operator /
//  key_equ    in   1      evaluate
//  key_clr    in   1      clear all, exit error
//  disp_val   out  W      signed value to display
//  disp_res   out  1      1 = disp_val is a result/accumulator, 0 = operand in entry
//  digit_cnt  out  CNT_W  digits in current operand
//  busy       out  1      iterative mul/div in progress
//  err_ovf    out  1      sticky overflow
//  err_div0   out  1      sticky divide by zero
// BEHAVIOUR
//  Reset: all outputs 0; acc=0, operand=0, pending_op=NONE, state=ENTRY.
//  Keys: rising-edge detect on registered inputs; one event per cycle.
//   Priority: clr > equ > add/sub/mul/div (in that order) > neg > digit, lowest index first.
//  ENTRY, digit: operand = operand*10 +/- d (sign applied); digit_cnt++.
//   Digits beyond MAX_DIGITS are ignored. disp_val=operand, disp_res=0.
//  neg: toggles the sign flag; operand is negated. Valid before the first digit (leading minus).
//  Operator with >=1 digit since last operator: acc = acc <pending_op> operand
//   (pending NONE -> acc = operand); store new op; clear operand/digit_cnt.
//  Operator with no digits: replaces pending_op only, no arithmetic.
//  add/sub: 1 cycle, acc valid the cycle after the edge cycle.
//  mul/div -> state EXEC, busy=1 for exactly W+1 cycles, then back to ENTRY.
//   mul: shift-add over |operands|. div: restoring, truncates toward zero, remainder discarded.
//   Keys arriving while busy are discarded, except clr, which aborts immediately to cleared ENTRY.
//  equ: applies pending op as above, then state RESULT, disp_val=acc, disp_res=1.
//   RESULT + digit/neg: new expression (acc=0, pending=NONE) with that key.
//   RESULT + operator: chain continues from acc. equ in RESULT: no-op.
//  Overflow: exact result outside [-2**(W-1), 2**(W-1)-1] (W+1-bit add, 2W-bit product)
//   -> err_ovf=1, state ERROR, acc unchanged.
//  Division by 0 -> err_div0=1, ERROR, no EXEC cycles.
//  ERROR: all keys except clr ignored; clr clears flags and state. Reset mid-EXEC aborts cleanly.
// STRUCTURE
//  calc_pkg: op enum {NONE,ADD,SUB,MUL,DIV}, state enum {ENTRY,EXEC,RESULT,ERROR},
//   key priority constants.
//  Sub-module calc_muldiv_iter: start/op/a/b in; busy/done/q/ovf out; W+1-cycle latency.
// TESTING
//  2,3,sub,neg,4,5,6,sub,2,3,4 (x4 sub 234),equ -> disp_val=-457, disp_res=1, no errors.
//  1,2,mul,neg,5,equ -> busy high exactly W+1 cycles; disp_val=-60.
//  7,div,0,equ -> err_div0=1; digit 5 ignored; clr -> all flags 0, disp_val=0.
//  9 x9 digits,mul,9,equ (W=32) -> err_ovf=1, ERROR state; 10th digit earlier ignored, digit_cnt=9.
//  8,add,sub,3,equ -> 5 (operator replaced); then add,2,equ -> 7 (chain from result).
//  rst low mid-EXEC and clr mid-EXEC -> busy=0 next cycle, all state cleared.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and key bit positions for the chained keypad calculator.
package calc_pkg;

   typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
   typedef enum logic [1:0] {ST_ENTRY, ST_EXEC, ST_RESULT, ST_ERROR} st_e;
   typedef enum logic [2:0] {EV_NONE, EV_DIG, EV_NEG, EV_OP, EV_EQU, EV_CLR} ev_e;

   // Bit positions in the packed key vector; digits occupy bits 9..0.
   localparam int K_NEG = 10;
   localparam int K_ADD = 11;
   localparam int K_SUB = 12;
   localparam int K_MUL = 13;
   localparam int K_DIV = 14;
   localparam int K_EQU = 15;
   localparam int K_CLR = 16;
   localparam int NKEYS = 17;

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative signed multiply / truncating divide on magnitudes: W shift steps plus one
// sign/overflow step, so busy is high for exactly W+1 cycles.
module calc_muldiv_iter
   import calc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic         ovf
);

   localparam int CW = $clog2(W + 1);
   localparam logic [2*W-1:0] LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

   logic [CW-1:0]  cnt;
   logic           is_div, neg;
   logic [W-1:0]   x, mag_b, rem;
   logic [2*W-1:0] prod, mag;
   logic [W:0]     rem_sh, rem_sub;

   assign rem_sh  = {rem, x[W-1]};
   assign rem_sub = rem_sh - {1'b0, mag_b};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg    <= 1'b0;
         x      <= '0;
         mag_b  <= '0;
         rem    <= '0;
         prod   <= '0;
      end else if (abort) begin
         busy <= 1'b0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         is_div <= (op == OP_DIV);
         neg    <= a[W-1] ^ b[W-1];
         x      <= a[W-1] ? -a : a;
         mag_b  <= b[W-1] ? -b : b;
         rem    <= '0;
         prod   <= '0;
      end else if (busy) begin
         if (cnt == CW'(W)) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
               // Restoring step: quotient bits shift into x as dividend bits shift out.
               rem <= rem_sub[W] ? rem_sh[W-1:0] : rem_sub[W-1:0];
               x   <= {x[W-2:0], ~rem_sub[W]};
            end else begin
               prod <= {prod[2*W-2:0], 1'b0} + (x[W-1] ? {{W{1'b0}}, mag_b} : '0);
               x    <= {x[W-2:0], 1'b0};
            end
         end
      end
   end

   assign mag  = is_div ? {{W{1'b0}}, x} : prod;
   assign done = busy && (cnt == CW'(W));
   assign q    = neg ? -mag[W-1:0] : mag[W-1:0];
   assign ovf  = neg ? (mag > LIM) : (mag >= LIM);

endmodule

// File: rtl/calc_chain_engine.sv
// Keypad calculator core: edge-detected keys build signed operands and fold them
// left-to-right into an accumulator, with iterative mul/div and sticky error flags.
module calc_chain_engine
   import calc_pkg::*;
#(
   parameter int W          = 32,
   parameter int MAX_DIGITS = 9,
   parameter int CNT_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [9:0]          key_digit,
   input  logic                key_neg,
   input  logic                key_add,
   input  logic                key_sub,
   input  logic                key_mul,
   input  logic                key_div,
   input  logic                key_equ,
   input  logic                key_clr,
   output logic signed [W-1:0] disp_val,
   output logic                disp_res,
   output logic [CNT_W-1:0]    digit_cnt,
   output logic                busy,
   output logic                err_ovf,
   output logic                err_div0
);

   logic [NKEYS-1:0] key_raw, key_q, key_p, key_edge;
   logic [W-1:0]     acc, operand, op_ten, op_dig;
   logic [W:0]       sum_x, diff_x;
   logic             neg, exec_to_res, is_equ, add_ovf, sub_ovf;
   logic             md_start, md_abort, md_busy, md_done, md_ovf;
   logic [W-1:0]     md_q;
   logic [3:0]       dig;
   op_e              pending, ev_op;
   st_e              state;
   ev_e              ev;

   assign key_raw  = {key_clr, key_equ, key_div, key_mul, key_sub, key_add, key_neg, key_digit};
   assign key_edge = key_q & ~key_p;

   // Later assignments win, so the highest-priority key is written last.
   always_comb begin
      ev    = EV_NONE;
      ev_op = OP_NONE;
      dig   = '0;
      for (int i = 9; i >= 0; i--)
         if (key_edge[i]) begin ev = EV_DIG; dig = 4'(i); end
      if (key_edge[K_NEG]) ev = EV_NEG;
      if (key_edge[K_DIV]) begin ev = EV_OP; ev_op = OP_DIV; end
      if (key_edge[K_MUL]) begin ev = EV_OP; ev_op = OP_MUL; end
      if (key_edge[K_SUB]) begin ev = EV_OP; ev_op = OP_SUB; end
      if (key_edge[K_ADD]) begin ev = EV_OP; ev_op = OP_ADD; end
      if (key_edge[K_EQU]) ev = EV_EQU;
      if (key_edge[K_CLR]) ev = EV_CLR;
   end

   assign is_equ  = (ev == EV_EQU);
   assign op_ten  = (operand << 3) + (operand << 1);
   assign op_dig  = neg ? op_ten - W'(dig) : op_ten + W'(dig);
   assign sum_x   = {acc[W-1], acc} + {operand[W-1], operand};
   assign diff_x  = {acc[W-1], acc} - {operand[W-1], operand};
   assign add_ovf = sum_x[W] ^ sum_x[W-1];
   assign sub_ovf = diff_x[W] ^ diff_x[W-1];

   assign md_abort = (ev == EV_CLR);
   assign md_start = (state == ST_ENTRY) && (ev == EV_OP || is_equ) && (digit_cnt != '0) &&
                     (pending == OP_MUL || (pending == OP_DIV && operand != '0));

   calc_muldiv_iter #(.W(W)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .abort (md_abort),
      .op    (pending),
      .a     (acc),
      .b     (operand),
      .busy  (md_busy),
      .done  (md_done),
      .q     (md_q),
      .ovf   (md_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q       <= '0;
         key_p       <= '0;
         acc         <= '0;
         operand     <= '0;
         neg         <= 1'b0;
         digit_cnt   <= '0;
         pending     <= OP_NONE;
         state       <= ST_ENTRY;
         disp_res    <= 1'b0;
         err_ovf     <= 1'b0;
         err_div0    <= 1'b0;
         exec_to_res <= 1'b0;
      end else begin
         key_q <= key_raw;
         key_p <= key_q;
         if (ev == EV_CLR) begin
            acc       <= '0;
            operand   <= '0;
            neg       <= 1'b0;
            digit_cnt <= '0;
            pending   <= OP_NONE;
            state     <= ST_ENTRY;
            disp_res  <= 1'b0;
            err_ovf   <= 1'b0;
            err_div0  <= 1'b0;
         end else begin
            case (state)
               ST_ENTRY: begin
                  if (ev == EV_DIG && digit_cnt < CNT_W'(MAX_DIGITS)) begin
                     operand   <= op_dig;
                     digit_cnt <= digit_cnt + 1'b1;
                     disp_res  <= 1'b0;
                  end else if (ev == EV_NEG) begin
                     neg      <= ~neg;
                     operand  <= -operand;
                     disp_res <= 1'b0;
                  end else if (ev == EV_OP || is_equ) begin
                     pending     <= is_equ ? OP_NONE : ev_op;
                     state       <= is_equ ? ST_RESULT : ST_ENTRY;
                     exec_to_res <= is_equ;
                     if (digit_cnt != '0) begin
                        operand   <= '0;
                        neg       <= 1'b0;
                        digit_cnt <= '0;
                        disp_res  <= 1'b1;
                        case (pending)
                           OP_ADD:
                              if (add_ovf) begin err_ovf <= 1'b1; state <= ST_ERROR; end
                              else acc <= sum_x[W-1:0];
                           OP_SUB:
                              if (sub_ovf) begin err_ovf <= 1'b1; state <= ST_ERROR; end
                              else acc <= diff_x[W-1:0];
                           OP_MUL: state <= ST_EXEC;
                           OP_DIV:
                              if (operand == '0) begin err_div0 <= 1'b1; state <= ST_ERROR; end
                              else state <= ST_EXEC;
                           default: acc <= operand;
                        endcase
                     end else if (is_equ) begin
                        disp_res <= 1'b1;
                     end
                  end
               end
               ST_EXEC: begin
                  if (md_done) begin
                     if (md_ovf) begin
                        err_ovf <= 1'b1;
                        state   <= ST_ERROR;
                     end else begin
                        acc   <= md_q;
                        state <= exec_to_res ? ST_RESULT : ST_ENTRY;
                     end
                  end
               end
               ST_RESULT: begin
                  // A digit or sign starts a fresh expression; an operator chains from acc.
                  if (ev == EV_DIG || ev == EV_NEG) begin
                     acc       <= '0;
                     pending   <= OP_NONE;
                     operand   <= (ev == EV_DIG) ? W'(dig) : '0;
                     digit_cnt <= (ev == EV_DIG) ? CNT_W'(1) : '0;
                     neg       <= (ev == EV_NEG);
                     disp_res  <= 1'b0;
                     state     <= ST_ENTRY;
                  end else if (ev == EV_OP) begin
                     pending <= ev_op;
                     state   <= ST_ENTRY;
                  end
               end
               ST_ERROR: ;
            endcase
         end
      end
   end

   assign disp_val = disp_res ? acc : operand;
   assign busy     = md_busy;

endmodule

// File: tb/tb_calc_chain_engine.sv
// Directed bench for the chained calculator core with hand-computed expectations.
module tb_calc_chain_engine;
   import calc_pkg::*;

   localparam int W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NKEYS-1:0]  kv  = '0;
   logic signed [W-1:0] disp_val;
   logic              disp_res, busy, err_ovf, err_div0;
   logic [3:0]        digit_cnt;

   int checks = 0;
   int errors = 0;

   calc_chain_engine #(.W(W), .MAX_DIGITS(9), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_digit (kv[9:0]),
      .key_neg   (kv[K_NEG]),
      .key_add   (kv[K_ADD]),
      .key_sub   (kv[K_SUB]),
      .key_mul   (kv[K_MUL]),
      .key_div   (kv[K_DIV]),
      .key_equ   (kv[K_EQU]),
      .key_clr   (kv[K_CLR]),
      .disp_val  (disp_val),
      .disp_res  (disp_res),
      .digit_cnt (digit_cnt),
      .busy      (busy),
      .err_ovf   (err_ovf),
      .err_div0  (err_div0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input int k);
      kv[k] = 1'b1;
      repeat (2) @(negedge clk);
      kv[k] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic press_num(input int v);
      int d[10];
      int n = 0;
      do begin
         d[n] = v % 10;
         v = v / 10;
         n++;
      end while (v > 0);
      for (int i = n - 1; i >= 0; i--) press(d[i]);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
      @(negedge clk);
   endtask

   // Press equ, hold operands in EXEC for a few cycles, then return (busy should be high).
   task automatic start_exec();
      kv[K_EQU] = 1'b1;
      repeat (2) @(negedge clk);
      kv[K_EQU] = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int nbusy;
      repeat (3) @(negedge clk);
      chk("rst_disp_val", disp_val, 0);
      chk("rst_disp_res", disp_res, 0);
      chk("rst_digit_cnt", digit_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_ovf, err_div0}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 23 - (-456) - 234 - 234 - 234 - 234 = -457
      press_num(23);
      chk("entry_23", disp_val, 23);
      chk("entry_cnt2", digit_cnt, 2);
      chk("entry_res0", disp_res, 0);
      press(K_SUB);
      chk("acc_23", disp_val, 23);
      chk("acc_res1", disp_res, 1);
      press(K_NEG);
      press_num(456);
      chk("lead_minus", disp_val, -456);
      for (int i = 0; i < 4; i++) begin
         press(K_SUB);
         press_num(234);
      end
      press(K_EQU);
      chk("chain_sub", disp_val, -457);
      chk("chain_res", disp_res, 1);
      chk("chain_noerr", {err_ovf, err_div0}, 0);

      // 12 * -5 with busy window measured
      press(K_CLR);
      press_num(12);
      press(K_MUL);
      press(K_NEG);
      press_num(5);
      chk("neg5", disp_val, -5);
      kv[K_EQU] = 1'b1;
      nbusy = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 1) kv[K_EQU] = 1'b0;
         if (busy) nbusy++;
      end
      chk("mul_busy_cycles", nbusy, W + 1);
      chk("mul_result", disp_val, -60);
      chk("mul_res", disp_res, 1);

      // divide by zero, keys ignored in error, clr recovers
      press(K_CLR);
      press_num(7);
      press(K_DIV);
      press_num(0);
      press(K_EQU);
      chk("div0_flag", err_div0, 1);
      chk("div0_nobusy", busy, 0);
      press_num(5);
      chk("div0_ignore_val", disp_val, 7);
      chk("div0_ignore_cnt", digit_cnt, 0);
      press(K_CLR);
      chk("clr_flags", {err_ovf, err_div0}, 0);
      chk("clr_val", disp_val, 0);

      // digit limit and multiply overflow
      press_num(999999999);
      press(9);
      chk("max_digits_cnt", digit_cnt, 9);
      chk("max_digits_val", disp_val, 999999999);
      press(K_MUL);
      press_num(9);
      press(K_EQU);
      wait_idle("ovf_timeout");
      chk("ovf_flag", err_ovf, 1);
      chk("ovf_acc_kept", disp_val, 999999999);
      press_num(3);
      chk("ovf_ignore_cnt", digit_cnt, 0);
      press(K_CLR);
      chk("ovf_clr", err_ovf, 0);

      // operator replacement, then chain from result
      press_num(8);
      press(K_ADD);
      press(K_SUB);
      press_num(3);
      press(K_EQU);
      chk("op_replace", disp_val, 5);
      press(K_ADD);
      press_num(2);
      press(K_EQU);
      chk("chain_from_res", disp_val, 7);

      // new expression from RESULT via neg; truncating division
      press(K_NEG);
      press_num(7);
      chk("new_expr_neg7", disp_val, -7);
      press(K_DIV);
      press_num(2);
      press(K_EQU);
      wait_idle("div_timeout");
      chk("div_trunc", disp_val, -3);

      // reset mid-EXEC
      press_num(12);
      press(K_MUL);
      press_num(5);
      start_exec();
      chk("exec_busy_a", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_busy", busy, 0);
      chk("rst_exec_val", disp_val, 0);
      chk("rst_exec_res", disp_res, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      press_num(4);
      press(K_ADD);
      press_num(1);
      press(K_EQU);
      chk("post_rst_expr", disp_val, 5);

      // clr mid-EXEC
      press(K_CLR);
      press_num(12);
      press(K_MUL);
      press_num(5);
      start_exec();
      chk("exec_busy_b", busy, 1);
      kv[K_CLR] = 1'b1;
      repeat (2) @(negedge clk);
      chk("clr_exec_busy", busy, 0);
      kv[K_CLR] = 1'b0;
      repeat (2) @(negedge clk);
      chk("clr_exec_val", disp_val, 0);
      chk("clr_exec_cnt", digit_cnt, 0);
      press_num(3);
      press(K_EQU);
      chk("post_clr_expr", disp_val, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
